// File: rtl/ch_req_fifo.sv
// Age-ordered request queue shared by several channels.
// An arbiter grant removes the oldest entry of the granted channel and returns its id one cycle later.
module ch_req_fifo #(
    parameter int DEPTH = 16,
    parameter int NCH   = 4,
    parameter int ID_W  = 4,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_flush,
    input  logic              p_req_val,
    input  logic [CH_W-1:0]   p_req_ch,
    input  logic [ID_W-1:0]   p_req_id,
    output logic              p_req_rdy,
    input  logic              p_arb_val,
    input  logic [CH_W-1:0]   p_arb_ch,
    output logic              p_sel_val,
    output logic [ID_W-1:0]   p_sel_req_id,
    output logic [CNT_W-1:0]  p_count,
    output logic [NCH-1:0]    p_ch_pend,
    output logic              p_err
);

    localparam logic [CH_W:0]    NCH_V   = (CH_W + 1)'(NCH);
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);

    logic            vld_q [DEPTH];
    logic [CH_W-1:0] ch_q  [DEPTH];
    logic [ID_W-1:0] id_q  [DEPTH];
    logic            vld_d [DEPTH];
    logic [CH_W-1:0] ch_d  [DEPTH];
    logic [ID_W-1:0] id_d  [DEPTH];

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sel_val_q;
    logic [ID_W-1:0]  sel_id_q;
    logic             err_q;

    logic             req_ch_ok;
    logic             arb_ch_ok;
    logic             hit;
    int               hit_idx;
    logic [ID_W-1:0]  hit_id;
    logic             grant_hit;
    logic             accept;
    int               tail;

    assign req_ch_ok = ({1'b0, p_req_ch} < NCH_V);
    assign arb_ch_ok = ({1'b0, p_arb_ch} < NCH_V);
    assign p_req_rdy = (count_q < DEPTH_V);
    assign accept    = p_req_val && p_req_rdy && req_ch_ok;

    // Oldest matching entry wins; the queue is compacted so the first hit is the oldest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
        hit_id  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && vld_q[i] && (ch_q[i] == p_arb_ch)) begin
                hit     = 1'b1;
                hit_idx = i;
                hit_id  = id_q[i];
            end
        end
        grant_hit = p_arb_val && arb_ch_ok && hit;
    end

    // Remove and compact first, then append behind the youngest survivor.
    always_comb begin
        vld_d = vld_q;
        ch_d  = ch_q;
        id_d  = id_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (grant_hit && (i >= hit_idx)) begin
                vld_d[i] = vld_q[i+1];
                ch_d[i]  = ch_q[i+1];
                id_d[i]  = id_q[i+1];
            end
        end
        if (grant_hit) begin
            vld_d[DEPTH-1] = 1'b0;
            ch_d[DEPTH-1]  = '0;
            id_d[DEPTH-1]  = '0;
        end
        tail = int'(count_q) - (grant_hit ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (i == tail)) begin
                vld_d[i] = 1'b1;
                ch_d[i]  = p_req_ch;
                id_d[i]  = p_req_id;
            end
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(grant_hit);
    end

    always_ff @(posedge clk) begin
        if (rst || p_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                ch_q[i]  <= '0;
                id_q[i]  <= '0;
            end
            count_q   <= '0;
            sel_val_q <= 1'b0;
            sel_id_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            ch_q      <= ch_d;
            id_q      <= id_d;
            count_q   <= count_d;
            sel_val_q <= grant_hit;
            sel_id_q  <= grant_hit ? hit_id : '0;
            err_q     <= (p_req_val && !req_ch_ok) || (p_arb_val && !grant_hit);
        end
    end

    always_comb begin
        p_ch_pend = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (ch_q[i] == CH_W'(c))) begin
                    p_ch_pend[c] = 1'b1;
                end
            end
        end
    end

    assign p_sel_val    = sel_val_q;
    assign p_sel_req_id = sel_id_q;
    assign p_count      = count_q;
    assign p_err        = err_q;

endmodule

// File: tb/tb_ch_req_fifo.sv
// Directed self-checking bench for ch_req_fifo with default parameters
// (DEPTH=16, NCH=4, ID_W=4); all expected values are hand-computed.
module tb_ch_req_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_flush = 1'b0;
    logic       p_req_val = 1'b0;
    logic [1:0] p_req_ch = '0;
    logic [3:0] p_req_id = '0;
    logic       p_req_rdy;
    logic       p_arb_val = 1'b0;
    logic [1:0] p_arb_ch = '0;
    logic       p_sel_val;
    logic [3:0] p_sel_req_id;
    logic [4:0] p_count;
    logic [3:0] p_ch_pend;
    logic       p_err;

    int total = 0;
    int bad   = 0;

    ch_req_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .p_flush      (p_flush),
        .p_req_val    (p_req_val),
        .p_req_ch     (p_req_ch),
        .p_req_id     (p_req_id),
        .p_req_rdy    (p_req_rdy),
        .p_arb_val    (p_arb_val),
        .p_arb_ch     (p_arb_ch),
        .p_sel_val    (p_sel_val),
        .p_sel_req_id (p_sel_req_id),
        .p_count      (p_count),
        .p_ch_pend    (p_ch_pend),
        .p_err        (p_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, then sample just after it.
    task automatic apply_stimulus(input logic fl, input logic rv, input logic [1:0] rch,
                                  input logic [3:0] rid, input logic av, input logic [1:0] ach);
        p_flush   = fl;
        p_req_val = rv;
        p_req_ch  = rch;
        p_req_id  = rid;
        p_arb_val = av;
        p_arb_ch  = ach;
        @(posedge clk);
        #1;
        p_flush   = 1'b0;
        p_req_val = 1'b0;
        p_arb_val = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset with junk on the inputs: reset must win.
        rst       = 1'b1;
        p_req_val = 1'b1;
        p_arb_val = 1'b1;
        p_flush   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        p_req_val = 1'b0;
        p_arb_val = 1'b0;
        p_flush   = 1'b0;
        check_output("rst_count", p_count, 0);
        check_output("rst_rdy", p_req_rdy, 1);
        check_output("rst_sel_val", p_sel_val, 0);
        check_output("rst_sel_id", p_sel_req_id, 0);
        check_output("rst_err", p_err, 0);
        check_output("rst_pend", p_ch_pend, 0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0);
            check_output("idle_count", p_count, 0);
            check_output("idle_rdy", p_req_rdy, 1);
            check_output("idle_sel_val", p_sel_val, 0);
        end

        $display("[TB] same-channel ordering");
        apply_stimulus(0, 1, 2'd1, 4'd0, 0, 0);
        apply_stimulus(0, 1, 2'd0, 4'd1, 0, 0);
        apply_stimulus(0, 1, 2'd1, 4'd2, 0, 0);
        apply_stimulus(0, 1, 2'd2, 4'd3, 0, 0);
        check_output("ord_count4", p_count, 4);
        check_output("ord_pend4", p_ch_pend, 4'b0111);
        apply_stimulus(0, 0, 0, 0, 1, 2'd1);
        check_output("ord_sel1_val", p_sel_val, 1);
        check_output("ord_sel1_id", p_sel_req_id, 0);
        check_output("ord_count3", p_count, 3);
        apply_stimulus(0, 0, 0, 0, 1, 2'd1);
        check_output("ord_sel2_val", p_sel_val, 1);
        check_output("ord_sel2_id", p_sel_req_id, 2);
        check_output("ord_count2", p_count, 2);
        check_output("ord_pend2", p_ch_pend, 4'b0101);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("ord_idle_sel_val", p_sel_val, 0);
        check_output("ord_idle_sel_id", p_sel_req_id, 0);

        $display("[TB] empty grant");
        apply_stimulus(0, 0, 0, 0, 1, 2'd3);
        check_output("empty_sel_val", p_sel_val, 0);
        check_output("empty_err", p_err, 1);
        check_output("empty_count", p_count, 2);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("empty_err_pulse", p_err, 0);
        apply_stimulus(0, 0, 0, 0, 1, 2'd0);
        check_output("drain_ch0_id", p_sel_req_id, 1);
        apply_stimulus(0, 0, 0, 0, 1, 2'd2);
        check_output("drain_ch2_id", p_sel_req_id, 3);
        check_output("drain_count", p_count, 0);
        check_output("drain_pend", p_ch_pend, 0);

        $display("[TB] full queue");
        for (int k = 0; k < 16; k++) apply_stimulus(0, 1, 2'd0, 4'(k), 0, 0);
        check_output("full_count", p_count, 16);
        check_output("full_rdy", p_req_rdy, 0);
        apply_stimulus(0, 1, 2'd0, 4'd9, 1, 2'd0);
        check_output("full_sel_val", p_sel_val, 1);
        check_output("full_sel_id", p_sel_req_id, 0);
        check_output("full_count15", p_count, 15);
        check_output("full_rdy_again", p_req_rdy, 1);
        for (int k = 1; k < 16; k++) begin
            apply_stimulus(0, 0, 0, 0, 1, 2'd0);
            check_output("full_drain_id", p_sel_req_id, k);
        end
        check_output("full_drain_count", p_count, 0);
        apply_stimulus(0, 0, 0, 0, 1, 2'd0);
        check_output("full_extra_sel_val", p_sel_val, 0);
        check_output("full_extra_err", p_err, 1);

        $display("[TB] simultaneous enqueue and grant");
        apply_stimulus(0, 1, 2'd2, 4'd5, 0, 0);
        apply_stimulus(0, 1, 2'd2, 4'd9, 1, 2'd2);
        check_output("sim_sel_id5", p_sel_req_id, 5);
        check_output("sim_count", p_count, 1);
        apply_stimulus(0, 0, 0, 0, 1, 2'd2);
        check_output("sim_sel_val9", p_sel_val, 1);
        check_output("sim_sel_id9", p_sel_req_id, 9);
        check_output("sim_count0", p_count, 0);

        $display("[TB] flush with entries held");
        for (int k = 0; k < 5; k++) apply_stimulus(0, 1, 2'(k), 4'(k + 1), 0, 0);
        check_output("fl_count5", p_count, 5);
        check_output("fl_pend", p_ch_pend, 4'b1111);
        apply_stimulus(1, 1, 2'd1, 4'd7, 1, 2'd0);
        check_output("fl_count", p_count, 0);
        check_output("fl_pend0", p_ch_pend, 0);
        check_output("fl_sel_val", p_sel_val, 0);
        check_output("fl_err", p_err, 0);
        apply_stimulus(0, 0, 0, 0, 1, 2'd0);
        check_output("fl_grant_err", p_err, 1);
        check_output("fl_grant_sel", p_sel_val, 0);

        $display("[TB] reset with entries held");
        for (int k = 0; k < 5; k++) apply_stimulus(0, 1, 2'(k), 4'(k + 10), 0, 0);
        check_output("rs_count5", p_count, 5);
        rst = 1'b1;
        apply_stimulus(0, 1, 2'd3, 4'd2, 1, 2'd1);
        rst = 1'b0;
        check_output("rs_count", p_count, 0);
        check_output("rs_pend", p_ch_pend, 0);
        check_output("rs_err", p_err, 0);
        check_output("rs_sel_val", p_sel_val, 0);
        apply_stimulus(0, 0, 0, 0, 1, 2'd1);
        check_output("rs_grant_err", p_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ch_req_fifo.md
CH_REQ_FIFO -- requirements
Module: ch_req_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of request entries, 2..64.
REQ-002 Parameter NCH, default 4: number of channels, 2..16.
REQ-003 Parameter ID_W, default 4: request-id width, 1..16.
REQ-004 Derived widths SHALL be CH_W = max(1, ceil(log2(NCH))) and CNT_W = ceil(log2(DEPTH+1)).
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- p_flush  in  1  synchronous clear of all entries.
- p_req_val  in  1  enqueue request valid.
- p_req_ch  in  CH_W  target channel of the request.
- p_req_id  in  ID_W  request id.
- p_req_rdy  out  1  enqueue can be accepted.
- p_arb_val  in  1  arbiter grant valid.
- p_arb_ch  in  CH_W  granted channel.
- p_sel_val  out  1  selected id valid; registered.
- p_sel_req_id  out  ID_W  selected id; registered.
- p_count  out  CNT_W  number of valid entries.
- p_ch_pend  out  NCH  bit c = 1 when channel c holds at least one entry.
- p_err  out  1  one-cycle pulse on a dropped request or an empty grant.

Function
REQ-006 Storage SHALL be an age-ordered array of DEPTH entries {valid, ch, id}, with index 0 the oldest.
REQ-007 A request SHALL be accepted when p_req_val=1, p_req_rdy=1 and p_req_ch<NCH; the entry is appended after the youngest valid entry.
REQ-008 p_req_rdy SHALL be (p_count<DEPTH) and SHALL be computed from current state only, so a full queue rejects a request even when a dequeue occurs in the same cycle.
REQ-009 A request with p_req_val=1 and p_req_ch>=NCH SHALL be discarded, and p_err SHALL be 1 in the next cycle.
REQ-010 On p_arb_val=1, the oldest valid entry with ch==p_arb_ch SHALL be removed.
- Its id appears on p_sel_req_id with p_sel_val=1 in the next cycle (latency 1).
- Younger entries shift down one index, so the array stays compacted.
REQ-011 On p_arb_val=1 with no matching entry (including p_arb_ch>=NCH):
- p_sel_val=0 next cycle;
- p_err=1 next cycle;
- no state change.
REQ-012 When p_arb_val=0, p_sel_val SHALL be 0 in the next cycle.
REQ-013 Whenever p_sel_val=0, p_sel_req_id SHALL be 0.
REQ-014 Simultaneous enqueue and dequeue in the same cycle SHALL both take effect:
- removal and compaction first, then append;
- p_count unchanged;
- the entry being enqueued is never eligible for selection in that cycle.
REQ-015 Per-channel order SHALL be FIFO. Entries of different channels never block each other.
REQ-016 p_count and p_ch_pend SHALL reflect registered state and update in the cycle after an accept or removal.
REQ-017 p_flush=1 SHALL invalidate all entries at the next edge.
- Requests and grants presented in the same cycle are ignored.
- p_sel_val=0 and p_err=0 next cycle.
REQ-018 The block SHALL keep p_count<=DEPTH at all times, with no wrap of count or index.

Reset
REQ-019 rst=1 at a rising edge SHALL produce, at the next edge:
- all entries invalid;
- p_count=0, p_ch_pend=0, p_sel_val=0, p_sel_req_id=0, p_err=0;
- p_req_rdy=1.
REQ-020 rst SHALL take priority over p_flush, requests and grants.
REQ-021 Reset asserted mid-operation SHALL discard all pending entries with no output pulse.

Verification
REQ-022 Reset then idle: p_count=0, p_req_rdy=1, p_sel_val=0 for 3 cycles.
REQ-023 Same-channel ordering:
- enqueue (ch1,id0), (ch0,id1), (ch1,id2), (ch2,id3);
- grant ch1 twice;
- expected: sel ids 0 then 2; p_ch_pend=4'b0101; p_count=2.
REQ-024 Empty grant: grant ch3 with nothing pending -> p_sel_val=0 and p_err=1 for one cycle; p_count unchanged.
REQ-025 Full queue:
- 16 enqueues to ch0 with ids 0..15 -> p_count=16, p_req_rdy=0;
- a 17th request with simultaneous grant ch0 -> sel id 0, request dropped, p_count=15.
REQ-026 Simultaneous enqueue and grant on the same channel with 1 entry (ch2, id5):
- enqueue (ch2, id9) with grant ch2 -> sel id 5;
- next grant ch2 -> sel id 9.
REQ-027 Mid-run p_flush and rst: each with 5 entries held -> p_count=0, p_ch_pend=0 next cycle; later grants give p_err=1.
